// File: rtl/l2_miss_request_port.sv
// Buffers L1 load-miss requests in a FIFO toward L2 (ack-to-issue >= 1 cycle) and returns tagged fills one cycle after arrival.
// Head fields hold stable under l2_request_ready backpressure; responses are never backpressured, bad tags only raise protocol_error.
module l2_miss_request_port #(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 512,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_ready,
  output logic                   miss_ack,
  input  logic [ADDR_WIDTH-1:0]  miss_addr,
  input  logic [IDX_W-1:0]       miss_idx,
  input  logic                   miss_synchronized,
  output logic                   l2_request_valid,
  input  logic                   l2_request_ready,
  output logic [ADDR_WIDTH-1:0]  l2_request_addr,
  output logic [IDX_W-1:0]       l2_request_id,
  output logic                   l2_request_synchronized,
  input  logic                   l2_rsp_valid,
  input  logic [IDX_W-1:0]       l2_rsp_id,
  input  logic [LINE_WIDTH-1:0]  l2_rsp_data,
  input  logic                   l2_rsp_status,
  output logic                   l2_response_valid,
  output logic [IDX_W-1:0]       l2_response_idx,
  output logic [LINE_WIDTH-1:0]  l2_response_data,
  output logic                   l2_response_status,
  output logic [NUM_ENTRIES-1:0] outstanding,
  output logic                   protocol_error
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [IDX_W-1:0]      idx;
    logic                  sync;
  } req_t;

  req_t                   mem [FIFO_DEPTH];
  req_t                   head_req;
  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   dup;
  logic                   rsp_hit;
  logic                   rsp_bad;
  logic [NUM_ENTRIES-1:0] set_mask;
  logic [NUM_ENTRIES-1:0] clr_mask;

  // Full uses the registered count only: a same-cycle pop never makes room for a push.
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign dup      = miss_ready && outstanding[miss_idx];
  assign miss_ack = miss_ready && !full && !outstanding[miss_idx];
  assign push     = miss_ack;

  assign l2_request_valid        = (count != '0);
  assign pop                     = l2_request_valid && l2_request_ready;
  assign head_req                = l2_request_valid ? mem[head] : '0;
  assign l2_request_addr         = head_req.addr;
  assign l2_request_id           = head_req.idx;
  assign l2_request_synchronized = head_req.sync;

  assign rsp_hit  = l2_rsp_valid && outstanding[l2_rsp_id];
  assign rsp_bad  = l2_rsp_valid && !outstanding[l2_rsp_id];
  assign set_mask = push    ? (NUM_ENTRIES'(1) << miss_idx)  : '0;
  assign clr_mask = rsp_hit ? (NUM_ENTRIES'(1) << l2_rsp_id) : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {miss_addr, miss_idx, miss_synchronized};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding    <= '0;
      protocol_error <= 1'b0;
    end else begin
      outstanding <= (outstanding & ~clr_mask) | set_mask;
      if (dup || rsp_bad) protocol_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l2_response_valid  <= 1'b0;
      l2_response_idx    <= '0;
      l2_response_data   <= '0;
      l2_response_status <= 1'b0;
    end else begin
      l2_response_valid <= rsp_hit;
      if (rsp_hit) begin
        l2_response_idx    <= l2_rsp_id;
        l2_response_data   <= l2_rsp_data;
        l2_response_status <= l2_rsp_status;
      end
    end
  end

endmodule

// File: tb/tb_l2_miss_request_port.sv
// Directed and random traffic for l2_miss_request_port against a queue-based reference model.
module tb_l2_miss_request_port;
  typedef logic [511:0] w_t;
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  idx;
    logic        sync;
  } req_s;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_ready;
  logic         miss_ack;
  logic [31:0]  miss_addr;
  logic [1:0]   miss_idx;
  logic         miss_synchronized;
  logic         l2_request_valid;
  logic         l2_request_ready;
  logic [31:0]  l2_request_addr;
  logic [1:0]   l2_request_id;
  logic         l2_request_synchronized;
  logic         l2_rsp_valid;
  logic [1:0]   l2_rsp_id;
  logic [511:0] l2_rsp_data;
  logic         l2_rsp_status;
  logic         l2_response_valid;
  logic [1:0]   l2_response_idx;
  logic [511:0] l2_response_data;
  logic         l2_response_status;
  logic [3:0]   outstanding;
  logic         protocol_error;

  int checks = 0;
  int errors = 0;

  // Reference model: request queue, outstanding set, sticky error, registered response.
  req_s         q[$];
  logic [3:0]   m_out;
  logic         m_err;
  logic         m_rv;
  logic [1:0]   m_ridx;
  logic [511:0] m_rdata;
  logic         m_rstat;
  logic [511:0] saved_data;

  l2_miss_request_port dut (
    .clk(clk), .reset(reset),
    .miss_ready(miss_ready), .miss_ack(miss_ack), .miss_addr(miss_addr),
    .miss_idx(miss_idx), .miss_synchronized(miss_synchronized),
    .l2_request_valid(l2_request_valid), .l2_request_ready(l2_request_ready),
    .l2_request_addr(l2_request_addr), .l2_request_id(l2_request_id),
    .l2_request_synchronized(l2_request_synchronized),
    .l2_rsp_valid(l2_rsp_valid), .l2_rsp_id(l2_rsp_id), .l2_rsp_data(l2_rsp_data),
    .l2_rsp_status(l2_rsp_status),
    .l2_response_valid(l2_response_valid), .l2_response_idx(l2_response_idx),
    .l2_response_data(l2_response_data), .l2_response_status(l2_response_status),
    .outstanding(outstanding), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_line(output logic [511:0] d);
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
  endtask

  // One clock: compare DUT with the model at the falling edge, advance the model, then cross the rising edge.
  task automatic cycle();
    logic exp_ack, hit, do_pop;
    logic [3:0] nout;
    @(negedge clk);
    exp_ack = miss_ready && (q.size() < 4) && !m_out[miss_idx];
    chk("miss_ack", w_t'(miss_ack), w_t'(exp_ack));
    chk("req_valid", w_t'(l2_request_valid), w_t'(q.size() != 0));
    if (q.size() != 0) begin
      chk("req_addr", w_t'(l2_request_addr), w_t'(q[0].addr));
      chk("req_id", w_t'(l2_request_id), w_t'(q[0].idx));
      chk("req_sync", w_t'(l2_request_synchronized), w_t'(q[0].sync));
    end
    chk("outstanding", w_t'(outstanding), w_t'(m_out));
    chk("protocol_error", w_t'(protocol_error), w_t'(m_err));
    chk("rsp_valid", w_t'(l2_response_valid), w_t'(m_rv));
    if (m_rv) begin
      chk("rsp_idx", w_t'(l2_response_idx), w_t'(m_ridx));
      chk("rsp_data", l2_response_data, m_rdata);
      chk("rsp_status", w_t'(l2_response_status), w_t'(m_rstat));
    end
    if (reset) begin
      q.delete();
      m_out = '0;
      m_err = 1'b0;
      m_rv = 1'b0;
    end else begin
      hit = l2_rsp_valid && m_out[l2_rsp_id];
      do_pop = (q.size() != 0) && l2_request_ready;
      if (miss_ready && m_out[miss_idx]) m_err = 1'b1;
      if (l2_rsp_valid && !m_out[l2_rsp_id]) m_err = 1'b1;
      nout = m_out;
      if (hit) nout[l2_rsp_id] = 1'b0;
      if (exp_ack) nout[miss_idx] = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (exp_ack) q.push_back('{addr: miss_addr, idx: miss_idx, sync: miss_synchronized});
      m_out = nout;
      m_rv = hit;
      if (hit) begin
        m_ridx = l2_rsp_id;
        m_rdata = l2_rsp_data;
        m_rstat = l2_rsp_status;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_out = '0; m_err = 1'b0; m_rv = 1'b0; m_ridx = '0; m_rdata = '0; m_rstat = 1'b0;
    reset = 1'b1; miss_ready = 1'b0; miss_addr = '0; miss_idx = '0; miss_synchronized = 1'b0;
    l2_request_ready = 1'b0; l2_rsp_valid = 1'b0; l2_rsp_id = '0; l2_rsp_data = '0; l2_rsp_status = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;

    // Reset state
    chk("rst_req_valid", w_t'(l2_request_valid), w_t'(0));
    chk("rst_req_addr", w_t'(l2_request_addr), w_t'(0));
    chk("rst_req_id", w_t'(l2_request_id), w_t'(0));
    chk("rst_req_sync", w_t'(l2_request_synchronized), w_t'(0));
    chk("rst_rsp_valid", w_t'(l2_response_valid), w_t'(0));
    chk("rst_rsp_idx", w_t'(l2_response_idx), w_t'(0));
    chk("rst_rsp_data", l2_response_data, w_t'(0));
    chk("rst_rsp_status", w_t'(l2_response_status), w_t'(0));
    chk("rst_outstanding", w_t'(outstanding), w_t'(0));
    chk("rst_error", w_t'(protocol_error), w_t'(0));
    chk("rst_ack_idle", w_t'(miss_ack), w_t'(0));
    miss_ready = 1'b1;
    #1 chk("rst_ack_follows_ready", w_t'(miss_ack), w_t'(1));

    // Single request, idx 2, answered later
    miss_addr = 32'h1000; miss_idx = 2'd2;
    cycle();
    miss_ready = 1'b0;
    chk("single_valid", w_t'(l2_request_valid), w_t'(1));
    chk("single_addr", w_t'(l2_request_addr), w_t'(32'h1000));
    chk("single_id", w_t'(l2_request_id), w_t'(2));
    chk("single_outstanding", w_t'(outstanding), w_t'(4'b0100));
    l2_request_ready = 1'b1;
    cycle();
    l2_request_ready = 1'b0;
    cycle(); cycle(); cycle();
    rand_line(saved_data);
    l2_rsp_valid = 1'b1; l2_rsp_id = 2'd2; l2_rsp_data = saved_data;
    cycle();
    l2_rsp_valid = 1'b0;
    chk("single_rsp_valid", w_t'(l2_response_valid), w_t'(1));
    chk("single_rsp_idx", w_t'(l2_response_idx), w_t'(2));
    chk("single_rsp_data", l2_response_data, saved_data);
    chk("single_outstanding_clr", w_t'(outstanding), w_t'(0));
    cycle();
    chk("single_rsp_one_cycle", w_t'(l2_response_valid), w_t'(0));

    // Fill the FIFO under backpressure
    for (int i = 0; i < 4; i++) begin
      miss_ready = 1'b1; miss_idx = 2'(i); miss_addr = 32'h2000 + 32'(i * 64);
      miss_synchronized = (i % 2) == 1;
      cycle();
    end
    miss_idx = 2'd0; miss_addr = 32'h3000;
    #1 chk("full_no_ack", w_t'(miss_ack), w_t'(0));
    cycle();
    miss_ready = 1'b0;
    chk("dup_sets_error", w_t'(protocol_error), w_t'(1));
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", w_t'(l2_request_addr), w_t'(32'h2000));
      chk("stall_id", w_t'(l2_request_id), w_t'(0));
      cycle();
    end
    l2_request_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_id", w_t'(l2_request_id), w_t'(i));
      chk("drain_addr", w_t'(l2_request_addr), w_t'(32'h2000 + 32'(i * 64)));
      chk("drain_sync", w_t'(l2_request_synchronized), w_t'((i % 2) == 1));
      cycle();
    end
    l2_request_ready = 1'b0;
    chk("drain_empty", w_t'(l2_request_valid), w_t'(0));

    // Back-to-back responses, odd ids report synchronized success
    for (int i = 0; i < 4; i++) begin
      l2_rsp_valid = 1'b1; l2_rsp_id = 2'(i); l2_rsp_status = (i % 2) == 1;
      rand_line(l2_rsp_data);
      cycle();
      chk("b2b_rsp_valid", w_t'(l2_response_valid), w_t'(1));
      chk("b2b_rsp_idx", w_t'(l2_response_idx), w_t'(i));
      chk("b2b_rsp_status", w_t'(l2_response_status), w_t'((i % 2) == 1));
    end
    l2_rsp_valid = 1'b0; l2_rsp_status = 1'b0;
    cycle();

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("reset_clears_error", w_t'(protocol_error), w_t'(0));

    // Response to an idle entry is dropped
    l2_rsp_valid = 1'b1; l2_rsp_id = 2'd1;
    cycle();
    l2_rsp_valid = 1'b0;
    chk("stray_rsp_dropped", w_t'(l2_response_valid), w_t'(0));
    chk("stray_rsp_error", w_t'(protocol_error), w_t'(1));
    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // Simultaneous push and pop at two entries
    miss_ready = 1'b1; miss_synchronized = 1'b0;
    miss_idx = 2'd0; miss_addr = 32'hA0; cycle();
    miss_idx = 2'd1; miss_addr = 32'hA1; cycle();
    miss_idx = 2'd2; miss_addr = 32'hA2; l2_request_ready = 1'b1; cycle();
    miss_ready = 1'b0;
    chk("pp_head1", w_t'(l2_request_id), w_t'(1));
    cycle();
    chk("pp_head2", w_t'(l2_request_id), w_t'(2));
    cycle();
    chk("pp_empty", w_t'(l2_request_valid), w_t'(0));
    l2_request_ready = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // Random traffic with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      reset = (i == 300);
      miss_ready = 1'($urandom_range(0, 1));
      miss_idx = 2'($urandom_range(0, 3));
      miss_addr = $urandom;
      miss_synchronized = 1'($urandom_range(0, 1));
      l2_request_ready = ($urandom_range(0, 3) != 0);
      l2_rsp_id = 2'($urandom_range(0, 3));
      l2_rsp_valid = ($urandom_range(0, 2) == 0) && (m_out[l2_rsp_id] || $urandom_range(0, 15) == 0);
      l2_rsp_status = 1'($urandom_range(0, 1));
      rand_line(l2_rsp_data);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
